// File: rtl/shift_ser_ctrl.sv
// ============================================================================
// Module      : shift_ser_ctrl
// Description : Load/shift sequencer for a WIDTH-bit serializer. It takes a
//               parallel word over valid/ready and emits it one bit per
//               serial beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_ser_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             sr_sel,
    output logic             sr_en,
    output logic             busy,
    output logic             done
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        din_ready = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        sr_sel    = 1'b0;
        sr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    sr_sel  = 1'b1;
                    sr_en   = 1'b1;
                    sr_d    = din;
                    order_d = lsb_first;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_out   = order_q ? sr_q[0] : sr_q[WIDTH-1];
                if (ser_ready) begin
                    sr_en = 1'b1;
                    sr_d  = order_q ? {1'b0, sr_q[WIDTH-1:1]}
                                    : {sr_q[WIDTH-2:0], 1'b0};
                    // Counter parks at its last value instead of wrapping.
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are forced quiet while reset is asserted, whatever the state.
        if (rst) begin
            din_ready = 1'b0;
            ser_valid = 1'b0;
            ser_out   = 1'b0;
            sr_sel    = 1'b0;
            sr_en     = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_ser_ctrl.sv
// ============================================================================
// Module      : tb_shift_ser_ctrl
// Description : Self-checking bench for shift_ser_ctrl: vector table, corner
//               sequences and random traffic against a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_ser_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         lsb_first;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_ready;
    logic         sr_sel;
    logic         sr_en;
    logic         busy;
    logic         done;

    shift_ser_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .lsb_first (lsb_first),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .sr_sel    (sr_sel),
        .sr_en     (sr_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Output vector order: {din_ready, ser_valid, ser_out, sr_sel, sr_en, busy, done}
    typedef struct {
        logic         r;
        logic [W-1:0] d;
        logic         dv;
        logic         lsb;
        logic         sr;
        logic [6:0]   exp;
    } vec_t;

    vec_t vq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sel_cyc;
    int done_cyc;

    // Reference model: bits still to be sent, plus a pending done pulse.
    logic q[$];
    logic done_p = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input logic r, input logic [W-1:0] d, input logic dv,
                       input logic lsb, input logic sr, input logic [6:0] exp);
        vec_t v;
        v.r = r; v.d = d; v.dv = dv; v.lsb = lsb; v.sr = sr; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic step(input logic r, input logic [W-1:0] d, input logic dv,
                        input logic lsb, input logic sr, input string tag,
                        output logic [6:0] act);
        logic       idle;
        logic       shifting;
        logic [6:0] exp;
        rst = r; din = d; din_valid = dv; lsb_first = lsb; ser_ready = sr;
        #2;
        idle     = (q.size() == 0) && !done_p;
        shifting = (q.size() != 0);
        if (r) exp = '0;
        else exp = {idle, shifting, shifting ? q[0] : 1'b0, idle & dv,
                    (idle & dv) | (shifting & sr), !idle, done_p};
        act = {din_ready, ser_valid, ser_out, sr_sel, sr_en, busy, done};
        chk(tag, {25'd0, act}, {25'd0, exp});
        if (act[3]) sel_cyc = cyc;
        if (act[0]) done_cyc = cyc;

        if (r) begin
            q.delete();
            done_p = 1'b0;
        end else if (done_p) begin
            done_p = 1'b0;
        end else if (shifting) begin
            if (sr) begin
                void'(q.pop_front());
                if (q.size() == 0) done_p = 1'b1;
            end
        end else if (dv) begin
            for (int i = 0; i < W; i++) q.push_back(lsb ? d[i] : d[W-1-i]);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic st(input logic r, input logic [W-1:0] d, input logic dv,
                      input logic lsb, input logic sr, input string tag);
        logic [6:0] a;
        step(r, d, dv, lsb, sr, tag, a);
    endtask

    initial begin
        logic [W-1:0] w;
        logic [6:0]   a;
        int           k;

        rst = 1'b1; din = '0; din_valid = 1'b0; lsb_first = 1'b0; ser_ready = 1'b0;

        // Reset with valid asserted, then MSB-first 0x0F.
        w = 8'h0F;
        add(1, w, 1, 0, 0, 7'b0000000);
        add(1, w, 1, 0, 0, 7'b0000000);
        add(0, w, 1, 0, 1, 7'b1001100);
        for (int i = 0; i < W; i++) add(0, 8'h00, 0, 0, 1, {2'b01, w[W-1-i], 4'b0110});
        add(0, 8'h00, 0, 0, 1, 7'b0000011);
        add(0, 8'h00, 0, 0, 1, 7'b1000000);
        // LSB-first 0x0F with lsb_first toggling mid-word.
        add(0, w, 1, 1, 1, 7'b1001100);
        for (int i = 0; i < W; i++) add(0, 8'h00, 0, logic'(i % 2), 1, {2'b01, w[i], 4'b0110});
        add(0, 8'h00, 0, 0, 1, 7'b0000011);
        add(0, 8'h00, 0, 0, 1, 7'b1000000);

        @(posedge clk);
        #1;
        foreach (vq[i]) begin
            step(vq[i].r, vq[i].d, vq[i].dv, vq[i].lsb, vq[i].sr, "table_model", a);
            chk($sformatf("table_row%0d", i), {25'd0, a}, {25'd0, vq[i].exp});
        end

        // Backpressure: 0xA0 MSB-first, stall three cycles after the 2nd bit.
        k = cyc; done_cyc = -1;
        st(0, 8'hA0, 1, 0, 1, "bp_acc");
        st(0, 8'h00, 0, 0, 1, "bp_b1");
        st(0, 8'h00, 0, 0, 1, "bp_b2");
        for (int i = 0; i < 3; i++) st(0, 8'h00, 0, 0, 0, "bp_stall");
        for (int i = 0; i < 8 && done_cyc < 0; i++) st(0, 8'h00, 0, 0, 1, "bp_run");
        chk("bp_done_latency", done_cyc - k, 12);
        st(0, 8'h00, 0, 0, 1, "bp_idle");

        // Busy collision: next word offered from k+3 while busy.
        k = cyc; sel_cyc = -1;
        st(0, 8'hC3, 1, 0, 1, "col_acc");
        sel_cyc = -1;
        st(0, 8'h00, 0, 0, 1, "col_b1");
        st(0, 8'h00, 0, 0, 1, "col_b2");
        for (int i = 0; i < 12 && sel_cyc < 0; i++) st(0, 8'h55, 1, 0, 1, "col_hold");
        chk("col_accept_cycle", sel_cyc - k, 10);
        for (int i = 0; i < 10; i++) st(0, 8'h00, 0, 0, 1, "col_drain");

        // Reset after the 4th beat, then a clean word.
        done_cyc = -1;
        st(0, 8'h96, 1, 1, 1, "rmw_acc");
        for (int i = 0; i < 4; i++) st(0, 8'h00, 0, 0, 1, "rmw_beat");
        st(1, 8'h00, 0, 0, 1, "rmw_rst");
        chk("rmw_sr_cleared", {24'd0, dut.sr_q}, 32'd0);
        st(0, 8'h00, 0, 0, 1, "rmw_idle");
        chk("rmw_no_done", done_cyc, -1);
        for (int i = 0; i < 11; i++) st(0, 8'h3C, (i == 0), 0, 1, "rmw_new");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            st(($urandom_range(0, 59) == 0), W'($urandom), logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
